// File: rtl/timer_pkg.sv
// Shared widths, field maxima and field-index enum for the countdown timer
// datapath, its control FSM and the display path.
package timer_pkg;
  localparam int TMR_MS_W  = 10;
  localparam int TMR_SEC_W = 6;
  localparam int TMR_MIN_W = 6;
  localparam int TMR_HR_W  = 5;

  localparam int TMR_MS_MAX  = 999;
  localparam int TMR_SEC_MAX = 59;
  localparam int TMR_MIN_MAX = 59;
  localparam int TMR_HR_MAX  = 23;

  typedef enum logic [1:0] {
    FIELD_MS  = 2'd0,
    FIELD_SEC = 2'd1,
    FIELD_MIN = 2'd2,
    FIELD_HR  = 2'd3
  } field_e;
endpackage

// File: rtl/timer_count_chain_if.sv
// Strobe/count bundle between the timer control FSM (master) and the count
// chain (slave). Zero-flag signals exist only with TIMER_ZERO_FLAGS_EN.
interface timer_count_chain_if;
  import timer_pkg::*;

  logic                 i_tick_sync;
  logic                 i_ms_up;
  logic                 i_ms_down;
  logic                 i_sec_up;
  logic                 i_sec_down;
  logic                 i_min_up;
  logic                 i_min_down;
  logic                 i_hr_up;
  logic                 i_hr_down;
  logic                 o_ms_pulse;
  logic                 o_ms_borrowdown;
  logic                 o_sec_borrowdown;
  logic                 o_min_borrowdown;
  logic                 o_hr_borrowdown;
  logic [TMR_MS_W-1:0]  o_ms;
  logic [TMR_SEC_W-1:0] o_sec;
  logic [TMR_MIN_W-1:0] o_min;
  logic [TMR_HR_W-1:0]  o_hr;
`ifdef TIMER_ZERO_FLAGS_EN
  logic                 o_allzero;
  logic                 o_almost_allzero;
`endif

  modport master (
    output i_tick_sync, i_ms_up, i_ms_down, i_sec_up, i_sec_down,
           i_min_up, i_min_down, i_hr_up, i_hr_down,
    input  o_ms_pulse, o_ms_borrowdown, o_sec_borrowdown, o_min_borrowdown,
           o_hr_borrowdown, o_ms, o_sec, o_min, o_hr
`ifdef TIMER_ZERO_FLAGS_EN
    , input o_allzero, o_almost_allzero
`endif
  );

  modport slave (
    input  i_tick_sync, i_ms_up, i_ms_down, i_sec_up, i_sec_down,
           i_min_up, i_min_down, i_hr_up, i_hr_down,
    output o_ms_pulse, o_ms_borrowdown, o_sec_borrowdown, o_min_borrowdown,
           o_hr_borrowdown, o_ms, o_sec, o_min, o_hr
`ifdef TIMER_ZERO_FLAGS_EN
    , output o_allzero, o_almost_allzero
`endif
  );
endinterface

// File: rtl/wrap_counter.sv
// One 0..MAX wrap-around field counter with up/down strobes and a
// combinational borrow that flags a decrement from zero.
module wrap_counter #(
  parameter int WIDTH = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] count,
  output logic             borrow
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] count_nxt;

  // Coincident up and down cancel: hold and never borrow.
  always_comb begin
    count_nxt = count;
    if (up && !down)
      count_nxt = (count == MAX_V) ? '0 : count + ONE_V;
    else if (down && !up)
      count_nxt = (count == '0) ? MAX_V : count - ONE_V;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else     count <= count_nxt;
  end

  assign borrow = down & ~up & (count == '0);
endmodule

// File: rtl/timer_count_chain.sv
// Countdown-timer count registers, 1 ms prescaler and borrow outputs.
// Optional TIMER_ZERO_FLAGS_EN adds registered all-zero / almost-all-zero flags.
module timer_count_chain
  import timer_pkg::*;
#(
  parameter int CLK_PER_MS = 50000,
  parameter int MS_MAX     = TMR_MS_MAX,
  parameter int SEC_MAX    = TMR_SEC_MAX,
  parameter int MIN_MAX    = TMR_MIN_MAX,
  parameter int HR_MAX     = TMR_HR_MAX
) (
  input logic                 i_clk,
  input logic                 i_rst,
  timer_count_chain_if.slave  tmr
);
  localparam int            PS_W    = $clog2(CLK_PER_MS);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_PER_MS - 1);
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] ps_cnt;

  // Sync takes priority over a coincident wrap so the next tick is a full period away.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ps_cnt         <= '0;
      tmr.o_ms_pulse <= 1'b0;
    end else if (tmr.i_tick_sync) begin
      ps_cnt         <= '0;
      tmr.o_ms_pulse <= 1'b0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt         <= '0;
      tmr.o_ms_pulse <= 1'b1;
    end else begin
      ps_cnt         <= ps_cnt + PS_ONE;
      tmr.o_ms_pulse <= 1'b0;
    end
  end

  wrap_counter #(.WIDTH(TMR_MS_W), .MAX(MS_MAX)) u_ms (
    .clk(i_clk), .rst(i_rst), .up(tmr.i_ms_up), .down(tmr.i_ms_down),
    .count(tmr.o_ms), .borrow(tmr.o_ms_borrowdown)
  );

  wrap_counter #(.WIDTH(TMR_SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk(i_clk), .rst(i_rst), .up(tmr.i_sec_up), .down(tmr.i_sec_down),
    .count(tmr.o_sec), .borrow(tmr.o_sec_borrowdown)
  );

  wrap_counter #(.WIDTH(TMR_MIN_W), .MAX(MIN_MAX)) u_min (
    .clk(i_clk), .rst(i_rst), .up(tmr.i_min_up), .down(tmr.i_min_down),
    .count(tmr.o_min), .borrow(tmr.o_min_borrowdown)
  );

  wrap_counter #(.WIDTH(TMR_HR_W), .MAX(HR_MAX)) u_hr (
    .clk(i_clk), .rst(i_rst), .up(tmr.i_hr_up), .down(tmr.i_hr_down),
    .count(tmr.o_hr), .borrow(tmr.o_hr_borrowdown)
  );

`ifdef TIMER_ZERO_FLAGS_EN
  function automatic int fld_next(input int cur, input int max, input logic up,
                                  input logic down);
    if (up && !down)      return (cur == max) ? 0 : cur + 1;
    else if (down && !up) return (cur == 0) ? max : cur - 1;
    else                  return cur;
  endfunction

  logic ms_nxt_zero, ms_nxt_le1, upper_nxt_zero;

  always_comb begin
    ms_nxt_zero    = fld_next(int'(tmr.o_ms), MS_MAX, tmr.i_ms_up, tmr.i_ms_down) == 0;
    ms_nxt_le1     = fld_next(int'(tmr.o_ms), MS_MAX, tmr.i_ms_up, tmr.i_ms_down) <= 1;
    upper_nxt_zero =
      (fld_next(int'(tmr.o_sec), SEC_MAX, tmr.i_sec_up, tmr.i_sec_down) == 0) &&
      (fld_next(int'(tmr.o_min), MIN_MAX, tmr.i_min_up, tmr.i_min_down) == 0) &&
      (fld_next(int'(tmr.o_hr),  HR_MAX,  tmr.i_hr_up,  tmr.i_hr_down)  == 0);
  end

  // Flags come from next-state values so they line up with the registered counts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmr.o_allzero        <= 1'b1;
      tmr.o_almost_allzero <= 1'b1;
    end else begin
      tmr.o_allzero        <= ms_nxt_zero & upper_nxt_zero;
      tmr.o_almost_allzero <= ms_nxt_le1 & upper_nxt_zero;
    end
  end
`endif
endmodule
